// File: rtl/zmips_pkg.sv
// Shared zMIPS definitions: ALU op codes, register index width and the bubble
// field values loaded into pipeline registers on stalls, flushes and reset.
package zmips_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h4;
  localparam logic [3:0] ALU_EOR = 4'h6;
  localparam logic [3:0] ALU_NOP = 4'h8;
  localparam logic [3:0] ALU_SLL = 4'hA;
  localparam logic [3:0] ALU_SRA = 4'hC;
  localparam logic [3:0] ALU_SRL = 4'hE;

  // A bubble is architecturally invisible: no write, no load, op/rd/data zero.
  localparam logic       BUBBLE_VALID   = 1'b0;
  localparam logic       BUBBLE_WR_EN   = 1'b0;
  localparam logic       BUBBLE_IS_LOAD = 1'b0;
  localparam logic [3:0] BUBBLE_ALU_OP  = ALU_ADD;

endpackage

// File: rtl/zmips_fwd_sel.sv
// Three-way operand forward select: MEM result, else WB result, else the
// registered operand. Register 0 is never forwarded.
module zmips_fwd_sel #(
  parameter int RW = 5,
  parameter int DW = 32
) (
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] reg_data,
  input  logic          mem_en,
  input  logic [RW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  input  logic          wb_en,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] data
);

  always_comb begin
    // NOTE: default assignment first so every path drives data (no latch).
    data = reg_data;
    if (idx != '0) begin
      if (mem_en && (mem_rd == idx))     data = mem_data;
      else if (wb_en && (wb_rd == idx))  data = wb_data;
    end
  end

endmodule

// File: rtl/zmips_id_ex.sv
// zMIPS ID/EX pipeline register with operand forwarding and hazard stalls.
// Build option: define ZMIPS_FWD_EN to include the MEM/WB forwarding muxes.
module zmips_id_ex
  import zmips_pkg::*;
#(
  parameter int RW = REG_W,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic [3:0]    id_alu_op,
  input  logic [4:0]    id_shamt,
  input  logic          id_shamt_var,
  input  logic          id_cin,
  input  logic [RW-1:0] id_rd,
  input  logic          id_wr_en,
  input  logic          id_is_load,
  input  logic          flush,
  input  logic          ex_stall,
  input  logic [RW-1:0] mem_rd,
  input  logic [RW-1:0] wb_rd,
  input  logic          mem_wr_en,
  input  logic          wb_wr_en,
  input  logic [DW-1:0] mem_data,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_op,
  output logic [4:0]    alu_shamt,
  output logic          alu_cin,
  output logic          ex_valid,
  output logic [RW-1:0] ex_rd,
  output logic          ex_wr_en,
  output logic          ex_is_load,
  output logic [DW-1:0] ex_store_data,
  output logic          id_stall
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic          use_imm;
    logic [3:0]    alu_op;
    logic [4:0]    shamt;
    logic          shamt_var;
    logic          cin;
    logic [RW-1:0] rd;
    logic          wr_en;
    logic          is_load;
  } idex_t;

  localparam idex_t BUBBLE = '{valid: BUBBLE_VALID, wr_en: BUBBLE_WR_EN,
                               is_load: BUBBLE_IS_LOAD, alu_op: BUBBLE_ALU_OP,
                               default: '0};

  idex_t         r;
  idex_t         id_in;
  logic          hazard;
  logic          fwd_mem_en;
  logic          fwd_wb_en;
  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;

  function automatic logic hit(input logic en, input logic [RW-1:0] rd,
                               input logic [RW-1:0] idx);
    return en && (rd != '0) && (rd == idx);
  endfunction

  assign id_in = '{valid: id_valid, rs: id_rs, rt: id_rt, rs_data: id_rs_data,
                   rt_data: id_rt_data, imm: id_imm, use_imm: id_use_imm,
                   alu_op: id_alu_op, shamt: id_shamt, shamt_var: id_shamt_var,
                   cin: id_cin, rd: id_rd, wr_en: id_wr_en, is_load: id_is_load};

`ifdef ZMIPS_FWD_EN
  // Only a load in EX cannot be bypassed: its data appears one stage later.
  assign hazard     = hit(ex_is_load, r.rd, id_rs) | hit(ex_is_load, r.rd, id_rt);
  assign fwd_mem_en = mem_wr_en;
  assign fwd_wb_en  = wb_wr_en;
`else
  // Without bypass, wait until every in-flight producer has retired from WB.
  assign hazard     = hit(ex_wr_en,  r.rd,   id_rs) | hit(ex_wr_en,  r.rd,   id_rt) |
                      hit(mem_wr_en, mem_rd, id_rs) | hit(mem_wr_en, mem_rd, id_rt) |
                      hit(wb_wr_en,  wb_rd,  id_rs) | hit(wb_wr_en,  wb_rd,  id_rt);
  assign fwd_mem_en = 1'b0;
  assign fwd_wb_en  = 1'b0;
`endif

  assign id_stall = ex_stall | (id_valid & hazard);

  // NOTE: async reset in the sensitivity list; all state updates use <=.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r <= BUBBLE;
    else if (flush)                r <= BUBBLE;
    else if (ex_stall)             r <= r;
    else if (id_valid && hazard)   r <= BUBBLE;
    else                           r <= id_in;
  end

  zmips_fwd_sel #(.RW(RW), .DW(DW)) u_fwd_rs (
    .idx(r.rs), .reg_data(r.rs_data),
    .mem_en(fwd_mem_en), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_en(fwd_wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .data(rs_fwd)
  );

  zmips_fwd_sel #(.RW(RW), .DW(DW)) u_fwd_rt (
    .idx(r.rt), .reg_data(r.rt_data),
    .mem_en(fwd_mem_en), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_en(fwd_wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .data(rt_fwd)
  );

  assign alu_a         = rs_fwd;
  assign alu_b         = r.use_imm ? r.imm : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign alu_shamt     = r.shamt_var ? rs_fwd[4:0] : r.shamt;
  assign alu_op        = r.alu_op;
  assign alu_cin       = r.cin;
  assign ex_valid      = r.valid;
  assign ex_rd         = r.rd;
  assign ex_wr_en      = r.valid & r.wr_en;
  assign ex_is_load    = r.valid & r.is_load;

endmodule

// File: tb/tb_zmips_id_ex.sv
// Self-checking bench for zmips_id_ex: vector table, directed hazard/stall
// sequences and a randomized run against a behavioural model.
module tb_zmips_id_ex;
  import zmips_pkg::*;

  localparam int RW = 5;
  localparam int DW = 32;
`ifdef ZMIPS_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [DW-1:0] rs_d;
    logic [DW-1:0] rt_d;
    logic [DW-1:0] imm;
    logic          use_imm;
    logic [3:0]    op;
    logic [4:0]    sh;
    logic          sv;
    logic          cin;
    logic [RW-1:0] rd;
    logic          wr;
    logic          ld;
  } instr_t;

  typedef struct {
    instr_t        i;
    logic          mwe;
    logic [RW-1:0] mrd;
    logic [DW-1:0] md;
    logic          wwe;
    logic [RW-1:0] wrd;
    logic [DW-1:0] wd;
    logic [DW-1:0] fa, fb, fst;   // expected with forwarding
    logic [4:0]    fsh;
    logic [DW-1:0] na, nb, nst;   // expected without forwarding
    logic [4:0]    nsh;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_use_imm, id_shamt_var, id_cin, id_wr_en, id_is_load;
  logic [RW-1:0] id_rs, id_rt, id_rd, mem_rd, wb_rd;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm, mem_data, wb_data;
  logic [3:0]    id_alu_op;
  logic [4:0]    id_shamt;
  logic          flush, ex_stall, mem_wr_en, wb_wr_en;
  logic [DW-1:0] alu_a, alu_b, ex_store_data;
  logic [3:0]    alu_op;
  logic [4:0]    alu_shamt;
  logic          alu_cin, ex_valid, ex_wr_en, ex_is_load, id_stall;
  logic [RW-1:0] ex_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  zmips_id_ex #(.RW(RW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_op(id_alu_op), .id_shamt(id_shamt),
    .id_shamt_var(id_shamt_var), .id_cin(id_cin), .id_rd(id_rd),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .flush(flush), .ex_stall(ex_stall),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_wr_en(mem_wr_en), .wb_wr_en(wb_wr_en),
    .mem_data(mem_data), .wb_data(wb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_cin(alu_cin), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
    .ex_is_load(ex_is_load), .ex_store_data(ex_store_data), .id_stall(id_stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_use_imm = 0; id_alu_op = 0; id_shamt = 0; id_shamt_var = 0; id_cin = 0;
    id_rd = 0; id_wr_en = 0; id_is_load = 0; flush = 0; ex_stall = 0;
    mem_wr_en = 0; mem_rd = 0; mem_data = 0; wb_wr_en = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic apply(input instr_t i);
    id_valid = 1; id_rs = i.rs; id_rt = i.rt; id_rs_data = i.rs_d; id_rt_data = i.rt_d;
    id_imm = i.imm; id_use_imm = i.use_imm; id_alu_op = i.op; id_shamt = i.sh;
    id_shamt_var = i.sv; id_cin = i.cin; id_rd = i.rd; id_wr_en = i.wr; id_is_load = i.ld;
  endtask

  task automatic set_env(input logic mwe, input logic [RW-1:0] mrd, input logic [DW-1:0] md,
                         input logic wwe, input logic [RW-1:0] wrd, input logic [DW-1:0] wd);
    mem_wr_en = mwe; mem_rd = mrd; mem_data = md; wb_wr_en = wwe; wb_rd = wrd; wb_data = wd;
  endtask

  task automatic clear_ex();
    @(negedge clk); idle(); flush = 1;
    @(negedge clk); flush = 0;
  endtask

  // ---------------- behavioural model for the random run ----------------
  instr_t m;
  logic   m_valid;

  function automatic instr_t zero_instr();
    instr_t z;
    z = '{default: '0};
    return z;
  endfunction

  function automatic instr_t cur_id();
    instr_t c;
    c = '{rs: id_rs, rt: id_rt, rs_d: id_rs_data, rt_d: id_rt_data, imm: id_imm,
          use_imm: id_use_imm, op: id_alu_op, sh: id_shamt, sv: id_shamt_var,
          cin: id_cin, rd: id_rd, wr: id_wr_en, ld: id_is_load};
    return c;
  endfunction

  function automatic logic [DW-1:0] fwd(input logic [RW-1:0] idx, input logic [DW-1:0] regv);
    if (!FWD || idx == 0) return regv;
    if (mem_wr_en && mem_rd == idx) return mem_data;
    if (wb_wr_en && wb_rd == idx) return wb_data;
    return regv;
  endfunction

  // Collect the destinations of producers decode must not read past.
  function automatic logic model_hazard();
    logic [RW-1:0] writers[$];
    if (FWD) begin
      if (m_valid && m.ld) writers.push_back(m.rd);
    end else begin
      if (m_valid && m.wr) writers.push_back(m.rd);
      if (mem_wr_en) writers.push_back(mem_rd);
      if (wb_wr_en) writers.push_back(wb_rd);
    end
    foreach (writers[k])
      if (writers[k] != 0 && (writers[k] == id_rs || writers[k] == id_rt)) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vt[7];
    instr_t ld_i, sub_i, add1, add2;
    int     stalls;

    vt[0] = '{'{5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, ALU_ADD, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0},
              1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
              32'd5, 32'd7, 32'd7, 5'd0, 32'd5, 32'd7, 32'd7, 5'd0};
    vt[1] = '{'{5'd1, 5'd2, 32'h11, 32'h22, 32'd0, 1'b0, ALU_OR, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0},
              1'b1, 5'd1, 32'h100, 1'b1, 5'd1, 32'h200,
              32'h100, 32'h22, 32'h22, 5'd0, 32'h11, 32'h22, 32'h22, 5'd0};
    vt[2] = '{'{5'd0, 5'd2, 32'h33, 32'h44, 32'd0, 1'b0, ALU_AND, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0},
              1'b1, 5'd0, 32'h100, 1'b1, 5'd0, 32'h200,
              32'h33, 32'h44, 32'h44, 5'd0, 32'h33, 32'h44, 32'h44, 5'd0};
    vt[3] = '{'{5'd1, 5'd2, 32'h11, 32'h22, 32'd0, 1'b0, ALU_EOR, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0},
              1'b1, 5'd5, 32'h555, 1'b1, 5'd2, 32'h200,
              32'h11, 32'h200, 32'h200, 5'd0, 32'h11, 32'h22, 32'h22, 5'd0};
    vt[4] = '{'{5'd1, 5'd2, 32'h11, 32'h22, 32'hFFFF_FFF0, 1'b1, ALU_ADD, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1},
              1'b1, 5'd2, 32'h99, 1'b0, 5'd0, 32'h0,
              32'h11, 32'hFFFF_FFF0, 32'h99, 5'd0, 32'h11, 32'hFFFF_FFF0, 32'h22, 5'd0};
    vt[5] = '{'{5'd1, 5'd2, 32'h3, 32'h80, 32'd0, 1'b0, ALU_SLL, 5'h1F, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0},
              1'b1, 5'd1, 32'h25, 1'b0, 5'd0, 32'h0,
              32'h25, 32'h80, 32'h80, 5'd5, 32'h3, 32'h80, 32'h80, 5'd3};
    vt[6] = '{'{5'd2, 5'd1, 32'h8000_0000, 32'h1, 32'd0, 1'b0, ALU_SRA, 5'd7, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0},
              1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h42,
              32'h8000_0000, 32'h42, 32'h42, 5'd7, 32'h8000_0000, 32'h1, 32'h1, 5'd7};

    idle();
    rst_n = 0;
    #12;
    check("reset_ex_valid", 32'(ex_valid), 0);
    check("reset_alu_a", alu_a, 0);
    @(negedge clk); rst_n = 1;

    // ---------------- vector table ----------------
    foreach (vt[k]) begin
      clear_ex();
      apply(vt[k].i);
      #1 check("vec_no_stall", 32'(id_stall), 0);
      @(negedge clk);
      id_valid = 0;
      set_env(vt[k].mwe, vt[k].mrd, vt[k].md, vt[k].wwe, vt[k].wrd, vt[k].wd);
      #1;
      check("vec_alu_a", alu_a, FWD ? vt[k].fa : vt[k].na);
      check("vec_alu_b", alu_b, FWD ? vt[k].fb : vt[k].nb);
      check("vec_store", ex_store_data, FWD ? vt[k].fst : vt[k].nst);
      check("vec_shamt", 32'(alu_shamt), 32'(FWD ? vt[k].fsh : vt[k].nsh));
      check("vec_op", 32'(alu_op), 32'(vt[k].i.op));
      check("vec_cin", 32'(alu_cin), 32'(vt[k].i.cin));
      check("vec_rd", 32'(ex_rd), 32'(vt[k].i.rd));
      check("vec_wr_en", 32'(ex_wr_en), 32'(vt[k].i.wr));
      check("vec_is_load", 32'(ex_is_load), 32'(vt[k].i.ld));
      check("vec_valid", 32'(ex_valid), 1);
    end

    // ---------------- load-use: LW r4 then SUB r5 = r1 - r4 ----------------
    ld_i  = '{5'd1, 5'd0, 32'h1000, 32'h0, 32'd4, 1'b1, ALU_ADD, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1};
    sub_i = '{5'd1, 5'd4, 32'h10, 32'hDEAD, 32'd0, 1'b0, ALU_SUB, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0};
    clear_ex();
    apply(ld_i);
    @(negedge clk); apply(sub_i);
    #1 check("lu_stall", 32'(id_stall), 1);
    @(negedge clk); set_env(1'b1, 5'd4, 32'hABC, 1'b0, 5'd0, 32'h0);
    #1;
    check("lu_bubble_valid", 32'(ex_valid), 0);
    check("lu_bubble_wr_en", 32'(ex_wr_en), 0);
    check("lu_stall_after", 32'(id_stall), FWD ? 0 : 1);
`ifdef ZMIPS_FWD_EN
    @(negedge clk); id_valid = 0;
    #1;
    check("lu_alu_b_fwd", alu_b, 32'hABC);
    check("lu_alu_a", alu_a, 32'h10);
    check("lu_op", 32'(alu_op), 32'(ALU_SUB));
    check("lu_wr_en", 32'(ex_wr_en), 1);
`endif

    // ---------------- dependent ADDs: r3 = r1 + r2 ; r6 = r3 + r3 ----------------
    add1 = '{5'd1, 5'd2, 32'h20, 32'h30, 32'd0, 1'b0, ALU_ADD, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0};
    add2 = '{5'd3, 5'd3, 32'h0, 32'h0, 32'd0, 1'b0, ALU_ADD, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0};
    clear_ex();
    apply(add1);
    @(negedge clk); apply(add2);
    #1 check("dep_stall_ex", 32'(id_stall), FWD ? 0 : 1);
`ifdef ZMIPS_FWD_EN
    @(negedge clk); id_valid = 0; set_env(1'b1, 5'd3, 32'h50, 1'b0, 5'd0, 32'h0);
    #1;
    check("dep_fwd_mem_a", alu_a, 32'h50);
    check("dep_fwd_mem_b", alu_b, 32'h50);
    set_env(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h50);
    #1 check("dep_fwd_wb_a", alu_a, 32'h50);
`else
    stalls = 1;
    @(negedge clk); set_env(1'b1, 5'd3, 32'h50, 1'b0, 5'd0, 32'h0);
    #1 if (id_stall) stalls++;
    check("dep_bubble_valid", 32'(ex_valid), 0);
    @(negedge clk); set_env(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h50);
    #1 if (id_stall) stalls++;
    @(negedge clk); set_env(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    id_rs_data = 32'h50; id_rt_data = 32'h50;
    #1 check("dep_released", 32'(id_stall), 0);
    check("dep_bubble_count", 32'(stalls), 3);
    @(negedge clk); id_valid = 0;
    #1;
    check("dep_alu_a", alu_a, 32'h50);
    check("dep_alu_b", alu_b, 32'h50);
    check("dep_rd", 32'(ex_rd), 6);
`endif

    // ---------------- ex_stall holds, then flush + ex_stall ----------------
    clear_ex();
    apply(vt[0].i);
    @(negedge clk); apply(vt[6].i); ex_stall = 1;
    #1 check("hold_stall_out", 32'(id_stall), 1);
    @(negedge clk);
    #1;
    check("hold_rd", 32'(ex_rd), 3);
    check("hold_alu_a", alu_a, 32'd5);
    flush = 1;
    @(negedge clk); flush = 0; ex_stall = 0; id_valid = 0;
    #1;
    check("flush_stall_valid", 32'(ex_valid), 0);
    check("flush_stall_wr_en", 32'(ex_wr_en), 0);

    // ---------------- asynchronous reset mid-instruction ----------------
    clear_ex();
    apply(vt[5].i);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("areset_valid", 32'(ex_valid), 0);
    check("areset_alu_a", alu_a, 0);
    check("areset_alu_b", alu_b, 0);
    check("areset_rd", 32'(ex_rd), 0);
    check("areset_wr_en", 32'(ex_wr_en), 0);
    check("areset_misc", 32'({alu_op, alu_shamt, alu_cin, ex_is_load}), 0);
    check("areset_store", ex_store_data, 0);
    check("areset_stall", 32'(id_stall), 0);
    @(negedge clk); rst_n = 1; idle();
    m = zero_instr(); m_valid = 0;

    // ---------------- randomized run vs model ----------------
    for (int n = 0; n < 400; n++) begin
      logic [DW-1:0] ea, et;
      logic          haz;
      @(negedge clk);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_rs_data   = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_use_imm   = 1'($urandom_range(0, 1));
      id_alu_op    = 4'($urandom_range(0, 15));
      id_shamt     = 5'($urandom_range(0, 31));
      id_shamt_var = 1'($urandom_range(0, 1));
      id_cin       = 1'($urandom_range(0, 1));
      id_rd        = 5'($urandom_range(0, 3));
      id_wr_en     = 1'($urandom_range(0, 1));
      id_is_load   = ($urandom_range(0, 2) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      ex_stall     = ($urandom_range(0, 4) == 0);
      set_env(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      #1;
      ea  = fwd(m.rs, m.rs_d);
      et  = fwd(m.rt, m.rt_d);
      haz = model_hazard();
      check("rnd_alu_a", alu_a, ea);
      check("rnd_alu_b", alu_b, m.use_imm ? m.imm : et);
      check("rnd_store", ex_store_data, et);
      check("rnd_shamt", 32'(alu_shamt), 32'(m.sv ? ea[4:0] : m.sh));
      check("rnd_op", 32'(alu_op), 32'(m.op));
      check("rnd_cin", 32'(alu_cin), 32'(m.cin));
      check("rnd_valid", 32'(ex_valid), 32'(m_valid));
      check("rnd_rd", 32'(ex_rd), 32'(m.rd));
      check("rnd_wr_en", 32'(ex_wr_en), 32'(m_valid & m.wr));
      check("rnd_is_load", 32'(ex_is_load), 32'(m_valid & m.ld));
      check("rnd_id_stall", 32'(id_stall), 32'(ex_stall | (id_valid & haz)));
      if (flush || (!ex_stall && id_valid && haz)) begin
        m = zero_instr(); m_valid = 0;
      end else if (!ex_stall) begin
        m = cur_id(); m_valid = id_valid;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zmips_id_ex.md
# zmips_id_ex

ID/EX pipeline register and operand-forwarding stage of the zMIPS core, directly upstream of the execute-stage ALU. Captures decoded operands and control from decode, then resolves RAW hazards against the MEM and WB stages by forwarding or by stalling. Drives the ALU's `a`, `b`, `op`, `shamt` and `cin` inputs. Inserts bubbles on load-use hazards, downstream stalls and flushes.

## Interface
- `RW`, default 5: register index width.
- `DW`, default 32: datapath width.
- `clk`, in, 1: core clock.
- `rst_n`, in, 1: reset. Asynchronous assert, active-low.
- `id_valid`, in, 1: decode holds a valid instruction.
- `id_rs`, `id_rt`, in, RW: source register indices.
- `id_rs_data`, `id_rt_data`, in, DW: register-file read data.
- `id_imm`, in, DW: extended immediate.
- `id_use_imm`, in, 1: ALU B operand is the immediate, not rt.
- `id_alu_op`, in, 4: ALU op. Bit 3 is the group, [2:1] is the operation, bit 0 is the B-invert/sub bit.
- `id_shamt`, in, 5: constant shift amount.
- `id_shamt_var`, in, 1: shift amount is the forwarded rs[4:0] (SLLV/SRAV/SRLV).
- `id_cin`, in, 1: adder carry-in.
- `id_rd`, in, RW: destination index.
- `id_wr_en`, in, 1: instruction writes rd.
- `id_is_load`, in, 1: instruction is a load.
- `flush`, in, 1: kill the instruction being captured this edge.
- `ex_stall`, in, 1: global downstream stall. Freezes EX, MEM and WB.
- `mem_rd`, `wb_rd`, in, RW: destination index in MEM and WB.
- `mem_wr_en`, `wb_wr_en`, in, 1: write enable in MEM and WB.
- `mem_data`, `wb_data`, in, DW: result available in MEM and WB.
- `alu_a`, `alu_b`, out, DW: ALU operands.
- `alu_op`, out, 4: ALU op.
- `alu_shamt`, out, 5: ALU shift amount.
- `alu_cin`, out, 1: ALU carry-in.
- `ex_valid`, out, 1: EX holds a valid instruction.
- `ex_rd`, out, RW: EX destination index.
- `ex_wr_en`, out, 1: EX write enable.
- `ex_is_load`, out, 1: EX instruction is a load.
- `ex_store_data`, out, DW: forwarded rt value, used for stores.
- `id_stall`, out, 1: decode must hold its instruction.

## Operation
- Register fields: valid, rs, rt, rs_data, rt_data, imm, use_imm, alu_op, shamt, shamt_var, cin, rd, wr_en, is_load.
- Capture rule, evaluated at each clk rising edge in priority order:
  1. `flush`: load a bubble.
  2. `ex_stall`: hold the register.
  3. Hazard stall: load a bubble.
  4. Otherwise: capture the id_* inputs, with valid = `id_valid`.
- Bubble definition: valid=0, wr_en=0, is_load=0, alu_op=0, rd=0. All data fields are 0.
- `ex_wr_en` and `ex_is_load` are gated by valid, so they are always 0 for a bubble.
- Forwarding is combinational on the register outputs. For each of rs and rt:
  - Use `mem_data` if mem_wr_en, mem_rd == idx and idx != 0.
  - Otherwise use `wb_data` if wb_wr_en, wb_rd == idx and idx != 0.
  - Otherwise use the registered data.
  - MEM has priority over WB.
- Register 0 is never forwarded and never causes a hazard.
- Output selection:
  - `alu_a` = forwarded rs.
  - `alu_b` = use_imm ? imm : forwarded rt.
  - `ex_store_data` = forwarded rt.
  - `alu_shamt` = shamt_var ? forwarded rs[4:0] : shamt.
- Load-use hazard: ex_valid, ex_is_load, ex_rd != 0, and ex_rd equals id_rs or id_rt. Raises `id_stall` for one cycle and inserts a single bubble.
- `id_stall` = `ex_stall` | (`id_valid` & hazard). It is 0 when `id_valid`=0.

## Timing
- Reset: all register fields take the bubble values. Every output is 0.
- Capture latency is 1 cycle. Forwarding and output muxing are purely combinational, with zero added latency.
- Load-use hazard costs exactly one bubble. On the following cycle the load is in MEM and forwards from `mem_data`.
- `ex_stall` freezes all register contents. Forward sources are frozen too, so outputs stay stable.
- Simultaneous events:
  - `flush` with `ex_stall`: flush wins.
  - `flush` with a hazard: bubble; `id_stall` is still asserted as computed.
- Reset mid-operation discards the in-flight instruction immediately, without waiting for a clock.

## Configuration
- `ZMIPS_FWD_EN` defined: forwarding muxes are present. Stalls occur only on load-use hazards.
- `ZMIPS_FWD_EN` undefined: no forwarding muxes; operands come straight from the register.
  - Hazard is any id_rs/id_rt (nonzero) that matches a nonzero rd with write enable in EX, MEM or WB.
  - Each such hazard inserts bubbles until the producer has left WB, up to 3 bubbles.
  - Port list is unchanged; mem_data and wb_data are ignored.

## Structure
- Shared package `zmips_pkg` holds:
  - ALU op localparams: ADD 0x0, SUB 0x1, AND 0x2, OR 0x4, EOR 0x6, NOP 0x8, SLL 0xA, SRA 0xC, SRL 0xE.
  - Register index width.
  - Bubble field constants.
- One sub-module, `zmips_fwd_sel`: 3-way forward select for one operand. Instantiated for rs and for rt.
- Hazard detection stays inline.

## Test plan
- Reset with rst_n=0 mid-instruction → all outputs 0 asynchronously; `id_stall`=0.
- ADD r3=r1+r2, rs_data=5, rt_data=7, no hazards → next cycle alu_a=5, alu_b=7, alu_op=0x0, ex_rd=3, ex_wr_en=1.
- mem_rd=1, mem_data=0x100 and wb_rd=1, wb_data=0x200 with forwarding → alu_a=0x100. With rs=0 instead, alu_a=registered value.
- Load to r4 in EX, decode issues SUB using rt=r4 → `id_stall`=1 for one cycle; bubble has ex_wr_en=0. Next cycle alu_b=mem_data.
- SLLV with rs forwarded value 0x25 → alu_shamt=5. Flush and ex_stall asserted together → next cycle ex_valid=0.
- With `ZMIPS_FWD_EN` undefined, back-to-back dependent ADDs → 3 bubbles, then correct operands from the register file.
